// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash read bridge.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    CMD,
    DATA,
    DONE,
    GAP
  } state_e;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [4:0] LAST_BIT_IDX = 5'd31;

  // The flash streams bytes in address order; the SoC wants byte 0 in bits [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: SCK generation, MOSI shift-out, MISO shift-in.
// A bit is CLK_DIV cycles of SCK low followed by CLK_DIV cycles of SCK high.
module spi_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] tx_data_i,
  input  logic        active_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic [31:0] rx_data_o,
  output logic        bit_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic             div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  // Next-state for the divider, SCK level and both shift registers.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch);
    // blocking '=' here, non-blocking '<=' only in the clocked block below.
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    if (load_i) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
      tx_d      = tx_data_i;
    end else if (active_i) begin
      if (div_last) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
        if (!sck_q) begin
          // Rising SCK edge: capture MISO.
          rx_d = {rx_q[30:0], miso_i};
        end else begin
          // Falling SCK edge: advance MOSI while SCK is low.
          tx_d = {tx_q[30:0], 1'b0};
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end
  end

  // State registers for the bit engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
    end
  end

  assign sck_o      = sck_q;
  assign mosi_o     = active_i & tx_q[31];
  assign rx_data_o  = rx_q;
  assign bit_done_o = active_i & sck_q & div_last;

endmodule

// File: rtl/spi_flash_mem.sv
// Read-only external-memory bridge backed by a SPI NOR flash (READ 0x03),
// with a one-word cache of the most recently fetched word.
module spi_flash_mem #(
  parameter int          CLK_DIV   = 1,
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter int          CS_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [7:0]  mem_addr,
  output logic [31:0] mem_rdata,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  import spi_flash_pkg::*;

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_e             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic               req_live_q, req_live_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               cache_valid_q, cache_valid_d;
  logic [7:0]         cache_addr_q, cache_addr_d;
  logic [31:0]        cache_data_q, cache_data_d;

  logic        cache_hit;
  logic        start_miss;
  logic        shift_active;
  logic        bit_done;
  logic        last_bit;
  logic [23:0] flash_addr;
  logic [31:0] rx_word;

  assign cache_hit  = cache_valid_q && (cache_addr_q == mem_addr);
  assign start_miss = (state_q == IDLE) && mem_valid && !cache_hit;
  assign flash_addr = BASE_ADDR + {14'd0, mem_addr, 2'b00};
  assign last_bit   = bit_done && (bit_cnt_q == LAST_BIT_IDX);

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (start_miss),
    .tx_data_i  ({SPI_CMD_READ, flash_addr}),
    .active_i   (shift_active),
    .miso_i     (spi_miso),
    .sck_o      (spi_sck),
    .mosi_o     (spi_mosi),
    .rx_data_o  (rx_word),
    .bit_done_o (bit_done)
  );

  // FSM state register; a reset mid-transfer simply drops back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state: command phase, data phase, then a chip-select gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_valid) state_d = cache_hit ? HIT : CMD;
      HIT:  state_d = IDLE;
      CMD:  if (last_bit) state_d = DATA;
      DATA: if (last_bit) state_d = DONE;
      DONE: state_d = GAP;
      GAP:  if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    shift_active = (state_q == CMD) || (state_q == DATA);
    spi_csn      = !shift_active;
    mem_ready    = (state_q == HIT) || ((state_q == DONE) && req_live_q);
  end

  // Datapath next-state: bit/gap counters, request tracking, read data and cache.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = '0;
    addr_d        = addr_q;
    req_live_d    = req_live_q;
    rdata_d       = rdata_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;

    if (start_miss) begin
      bit_cnt_d  = '0;
      addr_d     = mem_addr;
      req_live_d = 1'b1;
    end else if (bit_done) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // A requester that lets go mid-transfer gets no ready for this word.
    if (shift_active && !mem_valid) req_live_d = 1'b0;

    if (state_q == GAP) gap_cnt_d = gap_cnt_q + 1'b1;

    if ((state_q == IDLE) && mem_valid && cache_hit) rdata_d = cache_data_q;

    if ((state_q == DATA) && last_bit) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = addr_q;
      cache_data_d  = byte_swap(rx_word);
      if (req_live_q && mem_valid) rdata_d = byte_swap(rx_word);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      addr_q        <= '0;
      req_live_q    <= 1'b0;
      rdata_q       <= '0;
      cache_valid_q <= 1'b0;
      // NOTE: only cache_valid_q must be reset for correctness; the tag and data
      // are cleared too because they are a single word and keep state deterministic.
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      addr_q        <= addr_d;
      req_live_q    <= req_live_d;
      rdata_q       <= rdata_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign mem_rdata = rdata_q;

endmodule
